// File: rtl/set_clr_pulse_gen.sv
// set_clr_pulse_gen: two independent set/clear request channels.
// Each raw level is synchronized (2 flops), optionally debounced, and turned
// into a one-cycle pulse on every debounced 0->1 transition. A conflict pulse
// flags cycles where both channels pulse together; no priority is applied.
// Optional feature macro: SET_CLR_PULSE_GEN_DEBOUNCE_EN
//   defined   -> per-channel debounce counters (DEB_CYCLES, CNT_W used)
//   undefined -> stable level follows the second synchronizer flop directly
// Channel index 0 is set, channel index 1 is clear.
module set_clr_pulse_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic clr_raw,
  output logic set_pulse,
  output logic clr_pulse,
  output logic set_level,
  output logic clr_level,
  output logic conflict
);

  // Reject a debounce length the counter cannot represent.
  if (DEB_CYCLES < 1 || DEB_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_deb_cycles
    $error("set_clr_pulse_gen: DEB_CYCLES out of range 1..2^CNT_W-1");
  end

  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_level;
  logic [1:0] r_pulse;
  logic       r_conflict;

  logic [1:0] w_level_next;
  logic [1:0] w_pulse_next;

`ifdef SET_CLR_PULSE_GEN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt [2];
  logic [CNT_W-1:0] w_cnt_next [2];

  // Debounce: count consecutive cycles s2 differs from the stable level and
  // adopt s2 once the run reaches DEB_CYCLES; any agreeing cycle restarts it.
  always_comb begin
    w_level_next = r_level;
    w_pulse_next = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_cnt_next[i] = {CNT_W{1'b0}};
      if (r_s2[i] != r_level[i]) begin
        if (r_cnt[i] == DEB_LAST) begin
          w_level_next[i] = r_s2[i];
          w_pulse_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CNT_ONE;
        end
      end else begin
        w_cnt_next[i] = {CNT_W{1'b0}};
      end
    end
  end

  // Debounce counter storage, cleared by reset so a partial count is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt[0] <= {CNT_W{1'b0}};
      r_cnt[1] <= {CNT_W{1'b0}};
    end else begin
      r_cnt[0] <= w_cnt_next[0];
      r_cnt[1] <= w_cnt_next[1];
    end
  end
`else
  // No debounce: stable level tracks s2 every cycle, pulse on its rising edge.
  always_comb begin
    w_level_next = r_s2;
    w_pulse_next = r_s2 & ~r_level;
  end
`endif

  // Synchronizers, stable levels and registered pulse/conflict outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1       <= 2'b00;
      r_s2       <= 2'b00;
      r_level    <= 2'b00;
      r_pulse    <= 2'b00;
      r_conflict <= 1'b0;
    end else begin
      r_s1       <= {clr_raw, set_raw};
      r_s2       <= r_s1;
      r_level    <= w_level_next;
      r_pulse    <= w_pulse_next;
      r_conflict <= w_pulse_next[0] & w_pulse_next[1];
    end
  end

  assign set_pulse = r_pulse[0];
  assign clr_pulse = r_pulse[1];
  assign set_level = r_level[0];
  assign clr_level = r_level[1];
  assign conflict  = r_conflict;

endmodule

// File: tb/tb_set_clr_pulse_gen.sv
// Self-checking bench for set_clr_pulse_gen. Works with or without
// SET_CLR_PULSE_GEN_DEBOUNCE_EN; expected behaviour adapts to the build.
module tb_set_clr_pulse_gen;

  localparam int DEB = 4;
`ifdef SET_CLR_PULSE_GEN_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
  localparam int LAT    = DEB + 2;   // edges from first sampling edge to pulse
`else
  localparam bit DEB_ON = 1'b0;
  localparam int LAT    = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic set_raw;
  logic clr_raw;
  logic set_pulse, clr_pulse, set_level, clr_level, conflict;

  set_clr_pulse_gen #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .clr_raw(clr_raw),
    .set_pulse(set_pulse), .clr_pulse(clr_pulse),
    .set_level(set_level), .clr_level(clr_level), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sp_cnt   = 0;
  int cp_cnt   = 0;
  int cf_cnt   = 0;

  // reference model state (spec semantics: run length of disagreeing s2 samples)
  logic [1:0] m_s1, m_s2, m_lvl, m_pulse;
  int         m_run [2];
  logic       m_conf;
  logic [4:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model by one rising edge using the currently applied inputs
  task automatic model_edge();
    logic [1:0] raw;
    raw = {clr_raw, set_raw};
    if (!rst_n) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00; m_pulse = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pulse[i] = 1'b0;
        if (DEB_ON) begin
          if (m_s2[i] !== m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_pulse[i] = m_s2[i];
              m_lvl[i]   = m_s2[i];
              m_run[i]   = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else begin
          m_pulse[i] = m_s2[i] & ~m_lvl[i];
          m_lvl[i]   = m_s2[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    m_conf = m_pulse[0] & m_pulse[1];
    exp_q.push_back({m_pulse[0], m_pulse[1], m_lvl[0], m_lvl[1], m_conf});
  endtask

  // one clock: predict, let the edge happen, compare at the falling edge
  task automatic tick();
    logic [4:0] e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("sb_outputs", {27'd0, set_pulse, clr_pulse, set_level, clr_level, conflict},
            {27'd0, e});
    end
    if (set_pulse === 1'b1) sp_cnt++;
    if (clr_pulse === 1'b1) cp_cnt++;
    if (conflict === 1'b1)  cf_cnt++;
  endtask

  // tick until set_pulse is seen; n = ticks taken, -1 if the budget expires
  task automatic wait_set_pulse(input int budget, output int n);
    n = -1;
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (set_pulse === 1'b1) begin
        n = t;
        break;
      end
    end
  endtask

  typedef struct {
    logic rst_n;
    logic set_raw;
    logic clr_raw;
    int   cycles;
    int   exp_sp;
    int   exp_cp;
    int   exp_cf;
  } seg_t;

  seg_t tbl [9];
  int   n;

  initial begin
    rst_n = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
    @(negedge clk);

    tbl[0] = '{1'b0, 1'b0, 1'b0, 2,  0, 0, 0};       // reset
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4,  0, 0, 0};       // idle
    tbl[2] = '{1'b1, 1'b1, 1'b1, 12, 1, 1, 1};       // simultaneous rise
    tbl[3] = '{1'b1, 1'b1, 1'b1, 6,  0, 0, 0};       // held: no repeat
    tbl[4] = '{1'b1, 1'b0, 1'b0, 12, 0, 0, 0};       // fall: no pulse
    tbl[5] = '{1'b1, 1'b0, 1'b1, 3,  DEB_ON ? 0 : 0, DEB_ON ? 0 : 1, 0}; // 3-cycle clr glitch
    tbl[6] = '{1'b1, 1'b0, 1'b0, 10, 0, 0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1,  0, 0, 0};       // 1-cycle set glitch
    tbl[8] = '{1'b1, 1'b0, 1'b0, 10, DEB_ON ? 0 : 1, 0, 0};

    for (int s = 0; s < 9; s++) begin
      rst_n = tbl[s].rst_n; set_raw = tbl[s].set_raw; clr_raw = tbl[s].clr_raw;
      sp_cnt = 0; cp_cnt = 0; cf_cnt = 0;
      for (int c = 0; c < tbl[s].cycles; c++) tick();
      check($sformatf("seg%0d_set_pulses", s), sp_cnt, tbl[s].exp_sp);
      check($sformatf("seg%0d_clr_pulses", s), cp_cnt, tbl[s].exp_cp);
      check($sformatf("seg%0d_conflicts", s),  cf_cnt, tbl[s].exp_cf);
      if (s == 0) begin
        check("reset_outputs_zero",
              {27'd0, set_pulse, clr_pulse, set_level, clr_level, conflict}, 32'd0);
      end
    end

    // rising set: pulse exactly LAT edges later, one cycle wide, level held
    set_raw = 1'b1;
    wait_set_pulse(20, n);
    check("set_latency", n, LAT);
    check("set_level_at_pulse", {31'd0, set_level}, 32'd1);
    tick();
    check("set_pulse_one_cycle", {31'd0, set_pulse}, 32'd0);
    check("set_level_stays", {31'd0, set_level}, 32'd1);
    set_raw = 1'b0;
    repeat (12) tick();

    // reset mid-debounce with set held high: restart with full latency
    set_raw = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_outputs_zero",
          {27'd0, set_pulse, clr_pulse, set_level, clr_level, conflict}, 32'd0);
    rst_n = 1'b1;
    sp_cnt = 0;
    wait_set_pulse(20, n);
    check("post_reset_latency", n, LAT);
    repeat (20) tick();
    check("post_reset_one_pulse", sp_cnt, 1);
    set_raw = 1'b0;
    repeat (12) tick();

    // long hold: one pulse only; fall and rise gives a second pulse
    set_raw = 1'b1;
    sp_cnt = 0;
    repeat (1000) tick();
    check("long_hold_pulses", sp_cnt, 1);
    set_raw = 1'b0;
    repeat (12) tick();
    sp_cnt = 0;
    set_raw = 1'b1;
    repeat (12) tick();
    check("second_pulse", sp_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/set_clr_pulse_gen.md
SET_CLR_PULSE_GEN -- requirements
Module: set_clr_pulse_gen

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning consecutive cycles a synchronized input must differ from its stable level before the level changes; legal range 1..2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of each debounce counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port set_raw  input  1  unsynchronized set request level.
REQ-006 The block SHALL have port clr_raw  input  1  unsynchronized clear request level.
REQ-007 The block SHALL have port set_pulse  output  1  one-cycle pulse on a debounced set_raw rising edge; drives downstream in1.
REQ-008 The block SHALL have port clr_pulse  output  1  one-cycle pulse on a debounced clr_raw rising edge; drives downstream in2.
REQ-009 The block SHALL have port set_level  output  1  debounced stable level of set_raw.
REQ-010 The block SHALL have port clr_level  output  1  debounced stable level of clr_raw.
REQ-011 The block SHALL have port conflict  output  1  one-cycle pulse when set_pulse and clr_pulse are asserted in the same cycle.

Function
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Each channel SHALL have a counter: held at 0 while s2 equals the stable level; incremented while s2 differs from the stable level.
REQ-014 When s2 differs and the counter equals DEB_CYCLES-1, the stable level SHALL take s2 on that edge and the counter SHALL return to 0.
REQ-015 A single cycle with s2 equal to the stable level SHALL clear the counter; a glitch shorter than DEB_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-016 The pulse output SHALL be registered and asserted for exactly one cycle, in the same cycle the stable level goes 0->1; a 1->0 level change SHALL produce no pulse.
REQ-017 Latency: with raw held high from before rising edge k, the level and pulse SHALL be observed high after edge k+1+DEB_CYCLES.
REQ-018 The counter SHALL never exceed DEB_CYCLES-1 and SHALL NOT wrap.
REQ-019 Channels SHALL be fully independent; simultaneous qualified edges SHALL assert both pulses in the same cycle, with no priority applied here.
REQ-020 conflict SHALL be registered as set_pulse AND clr_pulse and asserted in the same cycle as those pulses.
REQ-021 A raw input held high indefinitely SHALL produce exactly one pulse; a new pulse SHALL require the debounced level to fall and rise again.

Reset
REQ-022 While rst_n is low at a rising clk edge, all synchronizer flops, counters and levels, plus set_pulse, clr_pulse and conflict, SHALL be 0 after that edge.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; after release, a raw input already high SHALL be treated as a new 0->1 edge and SHALL pulse once after full latency.
REQ-024 No output SHALL change asynchronously with rst_n.

Configuration
REQ-025 The macro SHALL be SET_CLR_PULSE_GEN_DEBOUNCE_EN.
REQ-026 With SET_CLR_PULSE_GEN_DEBOUNCE_EN defined, the debounce counters and behaviour of REQ-013..REQ-015 and REQ-018 SHALL be compiled in.
REQ-027 Without SET_CLR_PULSE_GEN_DEBOUNCE_EN, no counters SHALL exist; the stable level SHALL take s2 on every edge; latency SHALL be 3 edges; DEB_CYCLES and CNT_W SHALL be ignored; all other requirements SHALL be unchanged.

Verification
REQ-028 Default params, macro defined: set_raw 0->1 before edge 10, held -> set_level and set_pulse are 1 after edge 15; set_pulse is 0 after edge 16; set_level stays 1.
REQ-029 clr_raw high for 3 synchronized cycles then low, DEB_CYCLES=4 -> no clr_pulse; clr_level stays 0.
REQ-030 set_raw and clr_raw rise before the same edge -> set_pulse, clr_pulse and conflict all 1 in the same single cycle.
REQ-031 rst_n low for one edge when the set counter equals 2, set_raw held high -> all outputs 0; set_pulse occurs once, 5 edges after release.
REQ-032 Macro undefined: set_raw rises before edge 20 -> set_pulse is 1 after edge 22 only; a 1-cycle glitch yields a 1-cycle level change and one pulse.
REQ-033 set_raw held high for 1000 cycles -> exactly one set_pulse; after set_raw falls and then rises again, a second set_pulse occurs.
